// File: rtl/tdc_peak_select.sv
// Peak selector for the tdc_top beat stream: per-frame strongest sample,
// beat count and intensity sum, queued in a small result FIFO.
module tdc_peak_select #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned INT_MIN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [14:0] TDC_Odata,
    input  logic [4:0]  TDC_Oint,
    input  logic [1:0]  TDC_Onum,
    input  logic        TDC_Olast,
    input  logic        TDC_Ovalid,
    output logic        TDC_Oready,
    output logic [14:0] pk_data,
    output logic [4:0]  pk_int,
    output logic [2:0]  pk_cnt,
    output logic [7:0]  pk_sum,
    output logic        pk_miss,
    output logic        pk_valid,
    input  logic        pk_ready,
    output logic        pk_err,
    input  logic        err_clr
);

    localparam int unsigned DW = 15;
    localparam int unsigned IW = 5;
    localparam int unsigned NW = 2;
    localparam int unsigned CW = 3;
    localparam int unsigned SW = 8;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FW = PW + 1;

    localparam logic [DW-1:0] NO_PEAK = '1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [SW-1:0] SUM_MAX = '1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [IW-1:0] intens;
        logic [CW-1:0] cnt;
        logic [SW-1:0] sum;
        logic          miss;
    } result_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          rst_n_q;
    logic          acc;
    logic          push;
    logic          pop;

    logic [DW-1:0] best_data;
    logic [IW-1:0] best_int;
    logic          best_hit;
    logic [CW-1:0] cnt;
    logic [SW-1:0] sum;
    logic [NW-1:0] num;

    logic          qual;
    logic          take;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_int;
    logic          m_hit;
    logic [CW-1:0] m_cnt;
    logic [SW-1:0] m_sum;
    logic [SW:0]   sum_ext;
    logic [NW-1:0] num_eff;
    logic          len_bad;
    result_t       res;

    result_t       mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [FW-1:0] fifo_cnt;
    logic [FW-1:0] fifo_cnt_nxt;
    result_t       head;

    assign acc  = TDC_Ovalid & TDC_Oready;
    assign push = acc & TDC_Olast;
    assign pop  = pk_valid & pk_ready;

    // Delayed reset release so the stream stays stalled right after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rst_n_q <= 1'b0;
        end else begin
            rst_n_q <= 1'b1;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame FSM next state; single-beat frames never leave IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (acc && !TDC_Olast) state_nxt = S_ACC;
            S_ACC:   if (acc &&  TDC_Olast) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Merge the current beat into the running frame state
    always_comb begin
        qual    = (TDC_Oint >= IW'(INT_MIN));
        take    = qual & (~best_hit | (TDC_Oint > best_int));
        m_data  = take ? TDC_Odata : best_data;
        m_int   = take ? TDC_Oint  : best_int;
        m_hit   = best_hit | qual;
        m_cnt   = (cnt == CNT_MAX) ? CNT_MAX : cnt + CW'(1);
        sum_ext = {1'b0, sum} + (SW + 1)'(TDC_Oint);
        m_sum   = sum_ext[SW] ? SUM_MAX : sum_ext[SW-1:0];
        num_eff = (state == S_IDLE) ? TDC_Onum : num;
        len_bad = (m_cnt != (CW'(num_eff) + CW'(1)));
        res     = '0;
        res.data   = m_hit ? m_data : NO_PEAK;
        res.intens = m_hit ? m_int  : '0;
        res.cnt    = m_cnt;
        res.sum    = m_sum;
        res.miss   = ~m_hit;
    end

    // Running frame state; cleared on frame close
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_data <= '0;
            best_int  <= '0;
            best_hit  <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            num       <= '0;
        end else if (acc) begin
            if (TDC_Olast) begin
                best_data <= '0;
                best_int  <= '0;
                best_hit  <= 1'b0;
                cnt       <= '0;
                sum       <= '0;
                num       <= '0;
            end else begin
                best_data <= m_data;
                best_int  <= m_int;
                best_hit  <= m_hit;
                cnt       <= m_cnt;
                sum       <= m_sum;
                if (state == S_IDLE) begin
                    num <= TDC_Onum;
                end
            end
        end
    end

    // Sticky length error; a new error wins over a clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pk_err <= 1'b0;
        end else if (push && len_bad) begin
            pk_err <= 1'b1;
        end else if (err_clr) begin
            pk_err <= 1'b0;
        end
    end

    // FIFO occupancy after this edge
    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        case ({push, pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + FW'(1);
            2'b01:   fifo_cnt_nxt = fifo_cnt - FW'(1);
            default: fifo_cnt_nxt = fifo_cnt;
        endcase
    end

    // FIFO pointers, count and registered ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_cnt   <= '0;
            TDC_Oready <= 1'b0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            fifo_cnt   <= fifo_cnt_nxt;
            TDC_Oready <= rst_n_q & (fifo_cnt_nxt != FW'(DEPTH));
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (push) begin
            mem[wptr] <= res;
        end
    end

    assign head     = mem[rptr];
    assign pk_data  = head.data;
    assign pk_int   = head.intens;
    assign pk_cnt   = head.cnt;
    assign pk_sum   = head.sum;
    assign pk_miss  = head.miss;
    assign pk_valid = (fifo_cnt != '0);

endmodule

// File: tb/tb_tdc_peak_select.sv
// Self-checking bench for tdc_peak_select: directed vector table, corner
// sequences and a randomized run against a frame-level reference model.
module tb_tdc_peak_select;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned INT_MIN = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [14:0] TDC_Odata = '0;
    logic [4:0]  TDC_Oint = '0;
    logic [1:0]  TDC_Onum = '0;
    logic        TDC_Olast = 1'b0;
    logic        TDC_Ovalid = 1'b0;
    logic        TDC_Oready;
    logic [14:0] pk_data;
    logic [4:0]  pk_int;
    logic [2:0]  pk_cnt;
    logic [7:0]  pk_sum;
    logic        pk_miss;
    logic        pk_valid;
    logic        pk_ready = 1'b0;
    logic        pk_err;
    logic        err_clr = 1'b0;

    tdc_peak_select #(.DEPTH(DEPTH), .INT_MIN(INT_MIN)) dut (
        .clk(clk), .rst_n(rst_n),
        .TDC_Odata(TDC_Odata), .TDC_Oint(TDC_Oint), .TDC_Onum(TDC_Onum),
        .TDC_Olast(TDC_Olast), .TDC_Ovalid(TDC_Ovalid), .TDC_Oready(TDC_Oready),
        .pk_data(pk_data), .pk_int(pk_int), .pk_cnt(pk_cnt), .pk_sum(pk_sum),
        .pk_miss(pk_miss), .pk_valid(pk_valid), .pk_ready(pk_ready),
        .pk_err(pk_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] data;
        logic [4:0]  pint;
        logic [2:0]  cnt;
        logic [7:0]  sum;
        logic        miss;
    } res_t;

    typedef struct {
        int               nb;
        logic [1:0]       num;
        logic [9:0][14:0] d;
        logic [9:0][4:0]  i;
        logic [14:0]      e_data;
        logic [4:0]       e_int;
        logic [2:0]       e_cnt;
        logic [7:0]       e_sum;
        logic             e_miss;
        logic             e_err;
    } vec_t;

    res_t        exp_q[$];
    logic [14:0] fr_data[$];
    logic [4:0]  fr_int[$];
    logic [1:0]  fr_num = '0;
    logic        model_err = 1'b0;
    int          errs = 0;
    int          checks = 0;
    int          pops = 0;
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: evaluate a whole frame from its list of beats
    function automatic void model_close();
        res_t r;
        int   best;
        int   total;
        int   n;
        best  = -1;
        total = 0;
        n     = fr_int.size();
        for (int k = 0; k < n; k++) begin
            total += int'(fr_int[k]);
            if (int'(fr_int[k]) >= int'(INT_MIN) && (best < 0 || fr_int[k] > fr_int[best]))
                best = k;
        end
        r.data = (best < 0) ? 15'h7FFF : fr_data[best];
        r.pint = (best < 0) ? 5'd0 : fr_int[best];
        r.cnt  = (n > 7) ? 3'd7 : 3'(n);
        r.sum  = (total > 255) ? 8'd255 : 8'(total);
        r.miss = (best < 0);
        if (n != int'(fr_num) + 1) model_err = 1'b1;
        exp_q.push_back(r);
        fr_data.delete();
        fr_int.delete();
    endfunction

    function automatic vec_t mk(int nb, logic [1:0] num, logic [14:0] e_data, logic [4:0] e_int,
                                logic [2:0] e_cnt, logic [7:0] e_sum, logic e_miss, logic e_err);
        vec_t v;
        v.nb = nb; v.num = num; v.d = '0; v.i = '0;
        v.e_data = e_data; v.e_int = e_int; v.e_cnt = e_cnt; v.e_sum = e_sum;
        v.e_miss = e_miss; v.e_err = e_err;
        return v;
    endfunction

    // Drive one beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [14:0] d, input logic [4:0] i, input logic [1:0] n,
                             input logic l, output int waited);
        TDC_Odata = d; TDC_Oint = i; TDC_Onum = n; TDC_Olast = l; TDC_Ovalid = 1'b1;
        waited = 0;
        while (!TDC_Oready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!TDC_Oready) begin
            chk("send_ready_timeout", 32'(TDC_Oready), 32'd1);
        end else begin
            @(posedge clk); #1;
            if (fr_int.size() == 0) fr_num = n;
            fr_data.push_back(d);
            fr_int.push_back(i);
            if (l) model_close();
        end
        TDC_Ovalid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; TDC_Ovalid = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", 32'(TDC_Oready), 32'd0);
        chk("rst_valid", 32'(pk_valid), 32'd0);
        chk("rst_data", 32'(pk_data), 32'd0);
        chk("rst_int", 32'(pk_int), 32'd0);
        chk("rst_cnt", 32'(pk_cnt), 32'd0);
        chk("rst_sum", 32'(pk_sum), 32'd0);
        chk("rst_miss", 32'(pk_miss), 32'd0);
        chk("rst_err", 32'(pk_err), 32'd0);
        fr_data.delete(); fr_int.delete(); exp_q.delete(); model_err = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_edge1", 32'(TDC_Oready), 32'd0);
        @(posedge clk); #1;
        chk("ready_edge2", 32'(TDC_Oready), 32'd1);
    endtask

    task automatic apply_vec(input int idx);
        int w;
        pk_ready = 1'b0;
        for (int b = 0; b < tbl[idx].nb; b++)
            send_beat(tbl[idx].d[b], tbl[idx].i[b], tbl[idx].num, (b == tbl[idx].nb - 1), w);
        chk($sformatf("v%0d_valid", idx), 32'(pk_valid), 32'd1);
        chk($sformatf("v%0d_data", idx), 32'(pk_data), 32'(tbl[idx].e_data));
        chk($sformatf("v%0d_int", idx), 32'(pk_int), 32'(tbl[idx].e_int));
        chk($sformatf("v%0d_cnt", idx), 32'(pk_cnt), 32'(tbl[idx].e_cnt));
        chk($sformatf("v%0d_sum", idx), 32'(pk_sum), 32'(tbl[idx].e_sum));
        chk($sformatf("v%0d_miss", idx), 32'(pk_miss), 32'(tbl[idx].e_miss));
        chk($sformatf("v%0d_err", idx), 32'(pk_err), 32'(tbl[idx].e_err));
        pk_ready = 1'b1;
        @(posedge clk); #1;
        pk_ready = 1'b0;
        chk($sformatf("v%0d_popped", idx), 32'(pk_valid), 32'd0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk($sformatf("v%0d_errclr", idx), 32'(pk_err), 32'd0);
    endtask

    task automatic drain();
        pk_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_valid", 32'(pk_valid), 32'd0);
    endtask

    // Result monitor: pops compare against the model, held outputs must not move
    initial begin
        logic        hold;
        logic [31:0] held;
        res_t        r;
        hold = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                hold = 1'b0;
            end else begin
                if (hold && pk_valid)
                    chk("hold_stable", {pk_data, pk_int, pk_cnt, pk_sum, pk_miss}, held);
                if (pk_valid && pk_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 32'(pk_valid), 32'd0);
                    end else begin
                        r = exp_q.pop_front();
                        chk("mon_data", 32'(pk_data), 32'(r.data));
                        chk("mon_int", 32'(pk_int), 32'(r.pint));
                        chk("mon_cnt", 32'(pk_cnt), 32'(r.cnt));
                        chk("mon_sum", 32'(pk_sum), 32'(r.sum));
                        chk("mon_miss", 32'(pk_miss), 32'(r.miss));
                        pops++;
                    end
                end
                hold = pk_valid && !pk_ready;
                held = {pk_data, pk_int, pk_cnt, pk_sum, pk_miss};
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  w;
        int  p0;
        bit  done;
        int  nb;
        logic [1:0] num;

        tbl[0] = mk(4, 2'd3, 15'd200, 5'd9, 3'd4, 8'd23, 1'b0, 1'b0);
        tbl[0].d[0] = 15'd100; tbl[0].d[1] = 15'd200; tbl[0].d[2] = 15'd300; tbl[0].d[3] = 15'd400;
        tbl[0].i[0] = 5'd3; tbl[0].i[1] = 5'd9; tbl[0].i[2] = 5'd9; tbl[0].i[3] = 5'd2;
        tbl[1] = mk(2, 2'd1, 15'h7FFF, 5'd0, 3'd2, 8'd0, 1'b1, 1'b0);
        tbl[1].d[0] = 15'd5; tbl[1].d[1] = 15'd6;
        tbl[2] = mk(3, 2'd1, 15'd20, 5'd4, 3'd3, 8'd7, 1'b0, 1'b1);
        tbl[2].d[0] = 15'd10; tbl[2].d[1] = 15'd20; tbl[2].d[2] = 15'd30;
        tbl[2].i[0] = 5'd1; tbl[2].i[1] = 5'd4; tbl[2].i[2] = 5'd2;
        tbl[3] = mk(1, 2'd0, 15'h7FFE, 5'd31, 3'd1, 8'd31, 1'b0, 1'b0);
        tbl[3].d[0] = 15'h7FFE; tbl[3].i[0] = 5'd31;
        tbl[4] = mk(4, 2'd3, 15'd1, 5'd31, 3'd4, 8'd124, 1'b0, 1'b0);
        tbl[5] = mk(9, 2'd3, 15'd1, 5'd31, 3'd7, 8'd255, 1'b0, 1'b1);
        for (int b = 0; b < 9; b++) begin
            if (b < 4) begin tbl[4].d[b] = 15'(b + 1); tbl[4].i[b] = 5'd31; end
            tbl[5].d[b] = 15'(b + 1); tbl[5].i[b] = 5'd31;
        end
        tbl[6] = mk(2, 2'd2, 15'd8, 5'd6, 3'd2, 8'd11, 1'b0, 1'b1);
        tbl[6].d[0] = 15'd7; tbl[6].d[1] = 15'd8; tbl[6].i[0] = 5'd5; tbl[6].i[1] = 5'd6;
        tbl[7] = mk(3, 2'd2, 15'd60, 5'd1, 3'd3, 8'd2, 1'b0, 1'b0);
        tbl[7].d[0] = 15'd50; tbl[7].d[1] = 15'd60; tbl[7].d[2] = 15'd70;
        tbl[7].i[0] = 5'd0; tbl[7].i[1] = 5'd1; tbl[7].i[2] = 5'd1;

        do_reset();

        for (int v = 0; v < 8; v++) apply_vec(v);

        // New error in the same cycle as err_clr keeps the flag set
        err_clr = 1'b1;
        send_beat(15'd33, 5'd3, 2'd1, 1'b1, w);
        err_clr = 1'b0;
        chk("errclr_collide", 32'(pk_err), 32'd1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("errclr_after", 32'(pk_err), 32'd0);
        drain();

        // Backpressure: fill the FIFO, hold the fifth beat, then drain in order
        pk_ready = 1'b0;
        p0 = pops;
        for (int k = 0; k < 4; k++) send_beat(15'(1000 + k), 5'(k + 1), 2'd0, 1'b1, w);
        chk("full_ready", 32'(TDC_Oready), 32'd0);
        chk("full_head", 32'(pk_data), 32'd1000);
        TDC_Odata = 15'd1004; TDC_Oint = 5'd5; TDC_Onum = 2'd0; TDC_Olast = 1'b1; TDC_Ovalid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("full_held_ready", 32'(TDC_Oready), 32'd0);
        chk("full_held_head", 32'(pk_data), 32'd1000);
        pk_ready = 1'b1;
        @(posedge clk); #1;
        chk("reopen_ready", 32'(TDC_Oready), 32'd1);
        chk("reopen_head", 32'(pk_data), 32'd1001);
        send_beat(15'd1004, 5'd5, 2'd0, 1'b1, w);
        drain();
        chk("bp_results", 32'(pops - p0), 32'd5);

        // Back-to-back single-beat frames with a consumer that is always ready
        pk_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            send_beat(15'(2000 + k), 5'(k + 2), 2'd0, 1'b1, w);
            chk("tp_wait", 32'(w), 32'd0);
            chk("tp_valid", 32'(pk_valid), 32'd1);
            chk("tp_head", 32'(pk_data), 32'(2000 + k));
        end
        @(posedge clk); #1;
        chk("tp_empty", 32'(pk_valid), 32'd0);
        pk_ready = 1'b0;

        // Reset in the middle of a frame drops it
        send_beat(15'd11, 5'd20, 2'd3, 1'b0, w);
        send_beat(15'd12, 5'd21, 2'd3, 1'b0, w);
        chk("midframe_novalid", 32'(pk_valid), 32'd0);
        do_reset();
        apply_vec(0);

        // Randomized frames with random consumer backpressure
        model_err = 1'b0;
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 60; f++) begin
                    nb  = int'($urandom_range(1, 5));
                    num = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'(nb - 1);
                    for (int b = 0; b < nb; b++) begin
                        send_beat(15'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                                  num, (b == nb - 1), w);
                        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    pk_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        drain();
        chk("rand_err", 32'(pk_err), 32'(model_err));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
